// File: rtl/snax_alu_pe_driver_if.sv
// Stream bundle between the ALU PE driver, its operand/result streamers and the single ALU PE.
// The master modport is the driver's view; slave is the surrounding environment.
interface snax_alu_pe_driver_if #(
    parameter int unsigned DataWidth = 64
);
    logic [DataWidth-1:0] op_a_i;
    logic                 op_a_valid_i;
    logic                 op_a_ready_o;
    logic [DataWidth-1:0] op_b_i;
    logic                 op_b_valid_i;
    logic                 op_b_ready_o;
    logic [DataWidth-1:0] pe_a_o;
    logic                 pe_a_valid_o;
    logic                 pe_a_ready_i;
    logic [DataWidth-1:0] pe_b_o;
    logic                 pe_b_valid_o;
    logic                 pe_b_ready_i;
    logic [1:0]           pe_cfg_o;
    logic [DataWidth-1:0] pe_c_i;
    logic                 pe_c_valid_i;
    logic                 pe_c_ready_o;
    logic [DataWidth-1:0] res_o;
    logic                 res_valid_o;
    logic                 res_ready_i;

    modport master (
        input  op_a_i, op_a_valid_i, op_b_i, op_b_valid_i,
        input  pe_a_ready_i, pe_b_ready_i, pe_c_i, pe_c_valid_i, res_ready_i,
        output op_a_ready_o, op_b_ready_o, pe_a_o, pe_a_valid_o, pe_b_o, pe_b_valid_o,
        output pe_cfg_o, pe_c_ready_o, res_o, res_valid_o
    );

    modport slave (
        output op_a_i, op_a_valid_i, op_b_i, op_b_valid_i,
        output pe_a_ready_i, pe_b_ready_i, pe_c_i, pe_c_valid_i, res_ready_i,
        input  op_a_ready_o, op_b_ready_o, pe_a_o, pe_a_valid_o, pe_b_o, pe_b_valid_o,
        input  pe_cfg_o, pe_c_ready_o, res_o, res_valid_o
    );
endinterface

// File: rtl/snax_alu_pe_driver.sv
// Issues a job of operand pairs to a single ALU PE, keeping at most one pair in flight,
// and buffers the PE results in a small FIFO that drains to the downstream writer.
module snax_alu_pe_driver #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ResDepth  = 4,
    parameter int unsigned LenWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  len_i,
    input  logic [1:0]           alu_config_i,
    output logic                 busy_o,
    output logic                 done_o,
    snax_alu_pe_driver_if.master bus
);
    localparam int unsigned PtrWidth = $clog2(ResDepth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q;
    logic [LenWidth-1:0]   len_q;
    logic [LenWidth-1:0]   issued_q;
    logic [LenWidth-1:0]   written_q;
    logic [1:0]            cfg_q;
    logic                  pe_busy_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DataWidth-1:0]  fifo_mem_q [ResDepth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CntWidth-1:0]   count_q;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_free;
    logic c_ready;
    logic c_hs;
    logic can_issue;
    logic issue;
    logic pop;

    assign fifo_full  = (count_q == CntWidth'(ResDepth));
    assign fifo_empty = (count_q == '0);
    // The in-flight pair already owns a slot, so a new issue needs room beyond it.
    assign fifo_free  = ((count_q + CntWidth'(pe_busy_q)) < CntWidth'(ResDepth));

    assign c_ready = pe_busy_q & ~fifo_full;
    assign c_hs    = bus.pe_c_valid_i & c_ready;

    assign can_issue = (state_q == StRun) & (issued_q < len_q) & bus.op_a_valid_i &
                       bus.op_b_valid_i & (~pe_busy_q | c_hs) & fifo_free;
    assign issue     = can_issue & bus.pe_a_ready_i & bus.pe_b_ready_i;
    assign pop       = ~fifo_empty & bus.res_ready_i;

    assign bus.pe_a_o       = bus.op_a_i;
    assign bus.pe_b_o       = bus.op_b_i;
    assign bus.pe_a_valid_o = can_issue;
    assign bus.pe_b_valid_o = can_issue;
    assign bus.op_a_ready_o = issue;
    assign bus.op_b_ready_o = issue;
    assign bus.pe_cfg_o     = cfg_q;
    assign bus.pe_c_ready_o = c_ready;
    assign bus.res_o        = fifo_mem_q[rd_ptr_q];
    assign bus.res_valid_o  = ~fifo_empty;

    assign busy_o = busy_q;
    assign done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cfg_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            pe_busy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                issued_q <= issued_q + LenWidth'(1);
            end
            if (pop) begin
                written_q <= written_q + LenWidth'(1);
            end
            if (issue) begin
                pe_busy_q <= 1'b1;
            end else if (c_hs) begin
                pe_busy_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_q     <= len_i;
                        cfg_q     <= alu_config_i;
                        issued_q  <= '0;
                        written_q <= '0;
                        busy_q    <= 1'b1;
                        if (len_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issued_q == len_q) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (written_q == len_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (c_hs) begin
                fifo_mem_q[wr_ptr_q] <= bus.pe_c_i;
                wr_ptr_q             <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            count_q <= count_q + CntWidth'(c_hs) - CntWidth'(pop);
        end
    end
endmodule

// File: tb/tb_snax_alu_pe_driver.sv
// Randomised bench for snax_alu_pe_driver: streamer, PE and writer models around the DUT,
// with results scored against operand pairs combined by the selected ALU op.
module tb_snax_alu_pe_driver;
    localparam int unsigned DW = 64;
    localparam int unsigned RD = 4;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [1:0]    cfg = '0;
    logic          busy;
    logic          done;

    snax_alu_pe_driver_if #(.DataWidth(DW)) bus ();

    snax_alu_pe_driver #(.DataWidth(DW), .ResDepth(RD), .LenWidth(LW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .alu_config_i(cfg),
        .busy_o      (busy),
        .done_o      (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] a_q[$], b_q[$], exp_q[$], got_q[$];
    int a_prob, b_prob, pe_rdy_prob, res_rdy_prob, stray_prob, pe_lat_max, b_block;
    bit start_req;
    logic [LW-1:0] start_len;
    logic [1:0] start_cfg, cur_cfg;
    bit pe_full;
    logic [63:0] pe_res;
    int pe_wait;
    int proto_err, cfg_err, done_cnt, busy_cycles, pe_valid_cnt, issue_cnt, res_valid_cnt;
    int cyc, first_issue, last_issue;
    int tests_run = 0;
    int tests_failed = 0;

    function automatic bit chance(int p);
        return int'($urandom_range(99)) < p;
    endfunction

    function automatic logic [63:0] ref_op(logic [1:0] op, logic [63:0] a, logic [63:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a ^ b;
        endcase
    endfunction

    // Index of the first disagreement between got_q and exp_q, -1 if identical.
    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        if (got_q.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic set_ideal();
        a_prob = 100; b_prob = 100; pe_rdy_prob = 100; res_rdy_prob = 100;
        stray_prob = 0; pe_lat_max = 0; b_block = 0;
    endtask

    task automatic reset_env();
        a_q.delete(); b_q.delete(); exp_q.delete(); got_q.delete();
        pe_full = 1'b0; pe_wait = 0; start_req = 1'b0;
    endtask

    task automatic clear_stats();
        got_q.delete();
        proto_err = 0; cfg_err = 0; done_cnt = 0; busy_cycles = 0;
        pe_valid_cnt = 0; issue_cnt = 0; res_valid_cnt = 0; first_issue = -1; last_issue = -1;
    endtask

    task automatic fill(int n, logic [1:0] op);
        logic [63:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            a_q.push_back(a);
            b_q.push_back(b);
            exp_q.push_back(ref_op(op, a, b));
        end
    endtask

    task automatic drive();
        start = start_req; len = start_len; cfg = start_cfg; start_req = 1'b0;
        bus.op_a_valid_i = (a_q.size() > 0) && chance(a_prob);
        bus.op_a_i = {$urandom, $urandom};
        if (bus.op_a_valid_i) bus.op_a_i = a_q[0];
        if (b_block > 0) begin
            bus.op_b_valid_i = 1'b0;
            b_block--;
        end else begin
            bus.op_b_valid_i = (b_q.size() > 0) && chance(b_prob);
        end
        bus.op_b_i = {$urandom, $urandom};
        if (bus.op_b_valid_i) bus.op_b_i = b_q[0];
        bus.pe_a_ready_i = chance(pe_rdy_prob);
        bus.pe_b_ready_i = chance(pe_rdy_prob);
        if (pe_full && pe_wait == 0) begin
            bus.pe_c_valid_i = 1'b1;
            bus.pe_c_i = pe_res;
        end else begin
            bus.pe_c_valid_i = !pe_full && chance(stray_prob);
            bus.pe_c_i = {$urandom, $urandom};
        end
        bus.res_ready_i = chance(res_rdy_prob);
    endtask

    task automatic monitor();
        logic issue, c_hs;
        cyc++;
        if (bus.pe_a_valid_o !== bus.pe_b_valid_o) proto_err++;
        if (bus.op_a_ready_o !== bus.op_b_ready_o) proto_err++;
        if (bus.pe_a_valid_o && !(bus.op_a_valid_i && bus.op_b_valid_i)) proto_err++;
        issue = bus.pe_a_valid_o & bus.pe_a_ready_i & bus.pe_b_ready_i;
        if (bus.op_a_ready_o !== issue) proto_err++;
        c_hs = bus.pe_c_valid_i & bus.pe_c_ready_o;
        if (c_hs && !pe_full) proto_err++;
        if (issue && pe_full && !c_hs) proto_err++;
        if (bus.pe_a_valid_o) pe_valid_cnt++;
        if (busy && bus.pe_cfg_o !== cur_cfg) cfg_err++;
        if (bus.res_valid_o) res_valid_cnt++;
        if (bus.res_valid_o && bus.res_ready_i) got_q.push_back(bus.res_o);
        if (c_hs) pe_full = 1'b0;
        if (issue) begin
            if (a_q.size() == 0 || b_q.size() == 0) begin
                proto_err++;
            end else begin
                if (bus.pe_a_o !== a_q[0] || bus.pe_b_o !== b_q[0]) proto_err++;
                pe_res = ref_op(bus.pe_cfg_o, a_q[0], b_q[0]);
                void'(a_q.pop_front());
                void'(b_q.pop_front());
            end
            pe_full = 1'b1;
            pe_wait = $urandom_range(pe_lat_max);
            issue_cnt++;
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
        end else if (pe_full && pe_wait > 0) begin
            pe_wait--;
        end
        if (done) done_cnt++;
        if (busy) busy_cycles++;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(int n, logic [1:0] op);
        clear_stats();
        cur_cfg = op; start_len = LW'(n); start_cfg = op; start_req = 1'b1;
        step();
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_busy_done: got %b, want 00", {busy, done});
        end
        tests_run++;
        if ({bus.pe_a_valid_o, bus.pe_b_valid_o, bus.res_valid_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_valids: got %b, want 000",
                     {bus.pe_a_valid_o, bus.pe_b_valid_o, bus.res_valid_o});
        end
        tests_run++;
        if ({bus.op_a_ready_o, bus.op_b_ready_o, bus.pe_c_ready_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_readies: got %b, want 000",
                     {bus.op_a_ready_o, bus.op_b_ready_o, bus.pe_c_ready_o});
        end
        tests_run++;
        if (bus.pe_cfg_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_cfg: got %0d, want 0", bus.pe_cfg_o);
        end
    endtask

    task automatic test_add();
        bit to;
        int d;
        reset_env(); set_ideal();
        for (int i = 1; i <= 4; i++) begin
            a_q.push_back(64'(i));
            b_q.push_back(64'(10 * i));
            exp_q.push_back(64'(11 * i));
        end
        start_job(4, 2'd0);
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1) begin
            tests_failed++;
            $display("FAIL add_results: timeout=%0d first_diff=%0d got_n=%0d, want 4 in order",
                     to, d, got_q.size());
        end
        tests_run++;
        if (done_cnt !== 1 || proto_err !== 0) begin
            tests_failed++;
            $display("FAIL add_done_proto: done=%0d proto=%0d, want 1 and 0", done_cnt, proto_err);
        end
    endtask

    task automatic test_mul();
        bit to;
        int d;
        reset_env(); set_ideal();
        a_q = '{64'd3, 64'hFFFF_FFFF};
        b_q = '{64'd5, 64'd2};
        exp_q = '{64'd15, 64'h1_FFFF_FFFE};
        start_job(2, 2'd2);
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1) begin
            tests_failed++;
            $display("FAIL mul_results: timeout=%0d first_diff=%0d got_n=%0d, want 2",
                     to, d, got_q.size());
        end
        tests_run++;
        if (cfg_err !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL mul_cfg: cfg_err=%0d done=%0d, want 0 and 1", cfg_err, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        logic [1:0] op;
        reset_env(); set_ideal();
        op = 2'($urandom_range(3));
        fill(8, op);
        res_rdy_prob = 0;
        start_job(8, op);
        repeat (40) step();
        tests_run++;
        if (issue_cnt !== RD || got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_stall: issued=%0d popped=%0d, want %0d and 0",
                     issue_cnt, got_q.size(), RD);
        end
        res_rdy_prob = 100;
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL bp_release: timeout=%0d first_diff=%0d done=%0d, want 8 out, 1 done",
                     to, d, done_cnt);
        end
    endtask

    task automatic test_b_delay();
        bit to;
        int d;
        reset_env(); set_ideal();
        fill(3, 2'd1);
        start_job(3, 2'd1);
        b_block = 3;
        repeat (3) step();
        tests_run++;
        if (pe_valid_cnt !== 0 || issue_cnt !== 0 || a_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL bdelay_hold: pe_valid=%0d issued=%0d a_left=%0d, want 0 0 3",
                     pe_valid_cnt, issue_cnt, a_q.size());
        end
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1 || proto_err !== 0) begin
            tests_failed++;
            $display("FAIL bdelay_results: timeout=%0d first_diff=%0d proto=%0d, want ok",
                     to, d, proto_err);
        end
    endtask

    task automatic test_len_zero();
        bit to;
        reset_env(); set_ideal();
        fill(2, 2'd0);
        start_job(0, 2'd3);
        wait_done(to);
        tests_run++;
        if (to || busy_cycles !== 1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL len0_busy_done: timeout=%0d busy=%0d done=%0d, want 0 1 1",
                     to, busy_cycles, done_cnt);
        end
        tests_run++;
        if (pe_valid_cnt !== 0 || res_valid_cnt !== 0 || a_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL len0_quiet: pe_valid=%0d res_valid=%0d a_left=%0d, want 0 0 2",
                     pe_valid_cnt, res_valid_cnt, a_q.size());
        end
    endtask

    task automatic test_throughput();
        bit to;
        int d;
        reset_env(); set_ideal();
        fill(16, 2'd3);
        start_job(16, 2'd3);
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1 || (last_issue - first_issue) !== 15) begin
            tests_failed++;
            $display("FAIL throughput: timeout=%0d first_diff=%0d issue_span=%0d, want 15",
                     to, d, last_issue - first_issue);
        end
    endtask

    task automatic test_random();
        bit to;
        int d, n;
        logic [1:0] op;
        for (int j = 0; j < 6; j++) begin
            reset_env();
            a_prob = 50 + $urandom_range(50);
            b_prob = 50 + $urandom_range(50);
            pe_rdy_prob = 50 + $urandom_range(50);
            res_rdy_prob = 40 + $urandom_range(60);
            stray_prob = 30;
            pe_lat_max = $urandom_range(3);
            b_block = 0;
            n = 1 + $urandom_range(23);
            op = 2'($urandom_range(3));
            fill(n, op);
            start_job(n, op);
            wait_done(to);
            d = first_diff();
            tests_run++;
            if (to || d !== -1 || done_cnt !== 1) begin
                tests_failed++;
                $display("FAIL random_job%0d: len=%0d op=%0d timeout=%0d first_diff=%0d done=%0d",
                         j, n, op, to, d, done_cnt);
            end
            tests_run++;
            if (proto_err !== 0 || cfg_err !== 0) begin
                tests_failed++;
                $display("FAIL random_proto%0d: proto=%0d cfg_err=%0d, want 0 0",
                         j, proto_err, cfg_err);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bit to;
        int d;
        reset_env(); set_ideal();
        fill(6, 2'd0);
        start_job(6, 2'd0);
        for (int i = 0; i < 200 && got_q.size() < 2; i++) step();
        rst_n = 1'b0;
        bus.res_ready_i = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, bus.res_valid_o, bus.pe_a_valid_o, bus.pe_b_valid_o,
             bus.op_a_ready_o, bus.op_b_ready_o, bus.pe_c_ready_o} !== 8'h00 ||
            bus.pe_cfg_o !== 2'd0 || got_q.size() !== 2 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: busy=%b done=%b resv=%b pev=%b rdy=%b cfg=%0d got=%0d",
                     busy, done, bus.res_valid_o, bus.pe_a_valid_o, bus.op_a_ready_o,
                     bus.pe_cfg_o, got_q.size());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_env();
        fill(1, 2'd1);
        start_job(1, 2'd1);
        wait_done(to);
        d = first_diff();
        tests_run++;
        if (to || d !== -1 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midreset_restart: timeout=%0d first_diff=%0d done=%0d, want ok",
                     to, d, done_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        reset_env(); set_ideal(); clear_stats();
        start_len = '0; start_cfg = '0; cur_cfg = '0;
        bus.op_a_i = '0; bus.op_a_valid_i = 1'b0; bus.op_b_i = '0; bus.op_b_valid_i = 1'b0;
        bus.pe_a_ready_i = 1'b0; bus.pe_b_ready_i = 1'b0; bus.pe_c_i = '0;
        bus.pe_c_valid_i = 1'b0; bus.res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        @(posedge clk);
        #1;
        test_add();
        test_mul();
        test_backpressure();
        test_b_delay();
        test_len_zero();
        test_throughput();
        test_random();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
